// File: rtl/reset_flag_pkg.sv
// reset_flag_pkg
//   Shared definitions for the top-level reset flag generator and the
//   per-domain receivers: the mode encoding, the flag priority decode and
//   an overlap test for the flag bundle.
package reset_flag_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_RST  = 2'd1,
        MODE_INIT = 2'd2,
        MODE_RUN  = 2'd3
    } reset_mode_t;

    // Priority decode: reset beats initialize beats run.
    function automatic reset_mode_t flags_to_mode(input logic rst,
                                                  input logic init,
                                                  input logic en);
        if (rst)
            return MODE_RST;
        else if (init)
            return MODE_INIT;
        else if (en)
            return MODE_RUN;
        else
            return MODE_HALT;
    endfunction

    // True when more than one flag of the bundle is high.
    function automatic logic flags_overlap(input logic rst,
                                           input logic init,
                                           input logic en);
        return (rst & init) | (rst & en) | (init & en);
    endfunction

endpackage

// File: rtl/flag_sync_chain.sv
// flag_sync_chain
//   STAGES-deep single-bit synchronizer with synchronous clear.
//   Ports:
//     clk  - destination clock
//     clr  - synchronous clear, active-high, empties every stage
//     d    - asynchronous input bit
//     q    - synchronized output (last stage)
module flag_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (clr)
            stages <= '0;
        else
            stages <= {stages[STAGES-2:0], d};
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/reset_flag_domain_rx.sv
// reset_flag_domain_rx
//   Domain-side receiver for the top-level reset flag bundle. Synchronizes
//   clk_en/sync_rst/init into the local clock, decodes them by priority into
//   one command, runs a HALT/RST/INIT/RUN state machine with a minimum reset
//   hold, and acknowledges once the mode has been stable long enough.
//
//   Ports:
//     clk             - domain clock
//     sync_rst        - local synchronous reset, active-high
//     clk_en_in       - run flag from the generator (asynchronous)
//     sync_rst_in     - reset flag from the generator (asynchronous)
//     init_in         - initialize flag from the generator (asynchronous)
//     clk_en_out      - local clock enable (state RUN)
//     sync_rst_out    - local synchronous reset (state RST)
//     init_out        - local initialize flag (state INIT)
//     sync_ack_out    - settled acknowledge back to the generator
//     flag_err_out    - sticky overlap flag (RESET_FLAG_RX_ERRCNT_EN only)
//     flag_err_count  - saturating overlap count (RESET_FLAG_RX_ERRCNT_EN only)
//
//   Optional feature macro: RESET_FLAG_RX_ERRCNT_EN
import reset_flag_pkg::*;

module reset_flag_domain_rx #(
    parameter int SYNCSTAGES      = 2,
    parameter int SETTLECYCLES    = 4,
    parameter int RESETHOLDCYCLES = 3,
    parameter int ERRCNTWIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   clk_en_in,
    input  logic                   sync_rst_in,
    input  logic                   init_in,
    output logic                   clk_en_out,
    output logic                   sync_rst_out,
    output logic                   init_out,
    output logic                   sync_ack_out
`ifdef RESET_FLAG_RX_ERRCNT_EN
    ,
    output logic                   flag_err_out,
    output logic [ERRCNTWIDTH-1:0] flag_err_count
`endif
);

    localparam int HOLD_W   = $clog2(RESETHOLDCYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLECYCLES + 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(RESETHOLDCYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLECYCLES);

    generate
        if (SYNCSTAGES < 2 || SETTLECYCLES < 1 || RESETHOLDCYCLES < 1 || ERRCNTWIDTH < 1) begin : g_bad_param
            $error("reset_flag_domain_rx: parameter out of range");
        end
    endgenerate

    logic en_s, rst_s, init_s;

    flag_sync_chain #(.STAGES(SYNCSTAGES)) u_sync_en (
        .clk (clk), .clr (sync_rst), .d (clk_en_in),   .q (en_s)
    );
    flag_sync_chain #(.STAGES(SYNCSTAGES)) u_sync_rst (
        .clk (clk), .clr (sync_rst), .d (sync_rst_in), .q (rst_s)
    );
    flag_sync_chain #(.STAGES(SYNCSTAGES)) u_sync_init (
        .clk (clk), .clr (sync_rst), .d (init_in),     .q (init_s)
    );

    reset_mode_t         state;
    reset_mode_t         cmd;
    reset_mode_t         next_state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   next_hold;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] next_settle;
    logic                hold_block;
    logic                state_change;

    always_comb begin
        cmd          = flags_to_mode(rst_s, init_s, en_s);
        // RST cannot be left until it has been held for the minimum time.
        hold_block   = (state == MODE_RST) && (hold_cnt < HOLD_LAST);
        next_state   = state;
        if (cmd != state && !hold_block)
            next_state = cmd;
        state_change = (next_state != state);

        next_hold = hold_cnt;
        if (state_change)
            next_hold = '0;
        else if (state == MODE_RST && hold_cnt != HOLD_LAST)
            next_hold = hold_cnt + 1'b1;

        // A pending command (even one blocked by the hold) keeps the mode
        // unsettled.
        next_settle = settle_cnt;
        if (state_change || cmd != state)
            next_settle = '0;
        else if (settle_cnt != SETTLE_MAX)
            next_settle = settle_cnt + 1'b1;
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself (SYNCSTAGES+1 cycles after an input edge).
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state        <= MODE_HALT;
            hold_cnt     <= '0;
            settle_cnt   <= '0;
            clk_en_out   <= 1'b0;
            sync_rst_out <= 1'b0;
            init_out     <= 1'b0;
            sync_ack_out <= 1'b0;
        end else begin
            state        <= next_state;
            hold_cnt     <= next_hold;
            settle_cnt   <= next_settle;
            clk_en_out   <= (next_state == MODE_RUN);
            sync_rst_out <= (next_state == MODE_RST);
            init_out     <= (next_state == MODE_INIT);
            sync_ack_out <= (next_settle == SETTLE_MAX) && (next_state != MODE_HALT);
        end
    end

`ifdef RESET_FLAG_RX_ERRCNT_EN
    logic overlap;

    assign overlap = flags_overlap(rst_s, init_s, en_s);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            flag_err_out   <= 1'b0;
            flag_err_count <= '0;
        end else if (overlap) begin
            flag_err_out <= 1'b1;
            if (flag_err_count != {ERRCNTWIDTH{1'b1}})
                flag_err_count <= flag_err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reset_flag_domain_rx.sv
// tb_reset_flag_domain_rx
//   Self-checking bench for reset_flag_domain_rx. A cycle-indexed reference
//   model built from input history predicts each output after every edge.
//   Honours RESET_FLAG_RX_ERRCNT_EN when defined.
module tb_reset_flag_domain_rx;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  localparam int HOLD   = 3;
  localparam int ERRW   = 8;

  logic clk = 1'b0;
  logic sync_rst;
  logic clk_en_in, sync_rst_in, init_in;
  logic clk_en_out, sync_rst_out, init_out, sync_ack_out;
`ifdef RESET_FLAG_RX_ERRCNT_EN
  logic            flag_err_out;
  logic [ERRW-1:0] flag_err_count;
`endif

  reset_flag_domain_rx #(
    .SYNCSTAGES      (SYNC),
    .SETTLECYCLES    (SETTLE),
    .RESETHOLDCYCLES (HOLD),
    .ERRCNTWIDTH     (ERRW)
  ) dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .clk_en_in      (clk_en_in),
    .sync_rst_in    (sync_rst_in),
    .init_in        (init_in),
    .clk_en_out     (clk_en_out),
    .sync_rst_out   (sync_rst_out),
    .init_out       (init_out),
    .sync_ack_out   (sync_ack_out)
`ifdef RESET_FLAG_RX_ERRCNT_EN
    ,
    .flag_err_out   (flag_err_out),
    .flag_err_count (flag_err_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // reference model: modes 0=HALT 1=RST 2=INIT 3=RUN; history vectors {rst,init,en}
  logic [2:0] in_hist[$];
  int         mode_hist[$];
  bit         quiet_hist[$];
  int         m_err_cnt;
  bit         m_err;
  int         m_mode;
  bit         m_ack;

  function automatic int decode(input logic [2:0] v);
    if (v[2]) return 1;
    if (v[1]) return 2;
    if (v[0]) return 3;
    return 0;
  endfunction

  function automatic bit overlap(input logic [2:0] v);
    return (int'(v[0]) + int'(v[1]) + int'(v[2])) > 1;
  endfunction

  task automatic model_edge(input bit r, input logic [2:0] v);
    int prev, des, run, nw;
    bit quiet;
    logic [2:0] seen;
    if (r) begin
      // reset empties the synchronizers: everything in flight becomes 0
      foreach (in_hist[i]) in_hist[i] = 3'b000;
      in_hist.push_back(3'b000);
      mode_hist.push_back(0);
      quiet_hist.push_back(1'b0);
      m_err_cnt = 0;
      m_err     = 1'b0;
      m_mode    = 0;
      m_ack     = 1'b0;
    end else begin
      in_hist.push_back(v);
      seen = (in_hist.size() > SYNC) ? in_hist[in_hist.size()-1-SYNC] : 3'b000;
      des  = decode(seen);
      prev = (mode_hist.size() > 0) ? mode_hist[mode_hist.size()-1] : 0;
      run  = 0;
      for (int i = mode_hist.size()-1; i >= 0 && mode_hist[i] == 1 && run < HOLD; i--)
        run++;
      nw    = (prev == 1 && run < HOLD) ? prev : des;
      quiet = (nw == prev) && (des == prev);
      mode_hist.push_back(nw);
      quiet_hist.push_back(quiet);
      m_mode = nw;
      m_ack  = (nw != 0) && (quiet_hist.size() >= SETTLE);
      for (int i = 0; i < SETTLE && m_ack; i++)
        if (!quiet_hist[quiet_hist.size()-1-i]) m_ack = 1'b0;
      if (overlap(seen)) begin
        m_err = 1'b1;
        if (m_err_cnt < (1 << ERRW) - 1) m_err_cnt++;
      end
    end
  endtask

  // driver: apply inputs, take one edge, advance model, compare
  task automatic step(input bit r, input logic [2:0] v);
    sync_rst = r;
    {sync_rst_in, init_in, clk_en_in} = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
    check("outs", {28'd0, sync_rst_out, init_out, clk_en_out, sync_ack_out},
          {28'd0, m_mode == 1, m_mode == 2, m_mode == 3, m_ack});
`ifdef RESET_FLAG_RX_ERRCNT_EN
    check("err_flag", {31'd0, flag_err_out}, {31'd0, m_err});
    check("err_count", {24'd0, flag_err_count}, m_err_cnt);
`endif
  endtask

  task automatic run_for(input int n, input logic [2:0] v);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  int first_rst, first_ack, rst_len;

  initial begin
    sync_rst = 1'b1;
    {sync_rst_in, init_in, clk_en_in} = 3'b111;

    // local reset with all flags high
    step(1'b1, 3'b111);
    step(1'b1, 3'b111);
    check("reset_outs", {28'd0, sync_rst_out, init_out, clk_en_out, sync_ack_out}, 32'd0);

    // release into RST: output at cycle 3, ack at cycle 7
    first_rst = 0;
    first_ack = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 3'b100);
      if (sync_rst_out && first_rst == 0) first_rst = k;
      if (sync_ack_out && first_ack == 0) first_ack = k;
    end
    check("rst_latency", first_rst, 3);
    check("ack_latency", first_ack, 7);

    // full sequence RST -> INIT -> RUN
    run_for(10, 3'b010);
    run_for(12, 3'b001);

    // one-cycle reset pulse from RUN: exactly HOLD cycles of sync_rst_out
    rst_len = 0;
    step(1'b0, 3'b100);
    if (sync_rst_out) rst_len++;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 3'b001);
      if (sync_rst_out) rst_len++;
    end
    check("hold_len", rst_len, HOLD);
    check("run_back", {31'd0, clk_en_out}, 32'd1);

    // priority: init + en together
    run_for(8, 3'b011);
    check("prio_init", {30'd0, init_out, clk_en_out}, 32'd2);
    run_for(6, 3'b001);

    // settle restart: toggle RUN/INIT every 2 cycles, then hold steady
    for (int k = 0; k < 6; k++) begin
      run_for(2, 3'b001);
      run_for(2, 3'b010);
    end
    run_for(8, 3'b001);

    // drop to HALT
    run_for(12, 3'b000);
    check("halt_noack", {31'd0, sync_ack_out}, 32'd0);

    // mid-operation local reset while in RST hold
    run_for(6, 3'b001);
    step(1'b0, 3'b100);
    run_for(2, 3'b001);
    step(1'b1, 3'b001);
    run_for(8, 3'b001);

    // randomized bursts with occasional local reset
    for (int b = 0; b < 120; b++) begin
      logic [2:0] v;
      int len;
      v   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0)
        for (int i = 0; i < $urandom_range(1, 2); i++) step(1'b1, v);
      run_for(len, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
